bird_physics_engine: RTL

//  Parametrised bird-motion and game-state engine for the Flappy Bird datapath.
//  It integrates a signed velocity under gravity once per frame tick, applies flap impulses and clamps to a

---
 rtl/bird_physics_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bird_physics_engine.sv
// bird_physics_engine: bird motion integrator plus IDLE/FLY/PAUSE/DEAD game FSM.
// Physics, state and scores advance only on the one-clock frame tick. Flap
// edges and pipe_passed pulses are latched between ticks and consumed on tick.
// Optional feature macro FLAP_COOLDOWN_EN: after an accepted flap, further
// flaps are ignored for COOLDOWN FLY ticks.
module bird_physics_engine #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int V_W      = 7,
  parameter int SCORE_W  = 10,
  parameter int START_X  = 140,
  parameter int START_Y  = 280,
  parameter int Y_MIN    = 40,
  parameter int Y_MAX    = 465,
  parameter int FLAP_VEL = 10,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 15
`ifdef FLAP_COOLDOWN_EN
  , parameter int COOLDOWN = 4
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      flap,
  input  logic                      pause,
  input  logic                      collide,
  input  logic                      pipe_passed,
  input  logic                      restart,
  output logic [1:0]                game_state,
  output logic [SCORE_W-1:0]        current_score,
  output logic [SCORE_W-1:0]        highest_score,
  output logic [X_W-1:0]            bird_x,
  output logic [Y_W-1:0]            bird_y,
  output logic signed [V_W-1:0]     velocity
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, PAUSE = 2'd2, DEAD = 2'd3} state_t;

  // Position sum carries two extra bits so y plus a negative velocity stays signed-safe.
  localparam int YS_W = Y_W + 2;
  localparam logic signed [V_W:0]    GRAV_S  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]    VMIN_S  = -((V_W+1)'(VMAX));
  localparam logic signed [V_W-1:0]  FLAP_S  = V_W'(FLAP_VEL);
  localparam logic signed [YS_W-1:0] YMAX_S  = YS_W'(Y_MAX);
  localparam logic signed [YS_W-1:0] YMIN_S  = YS_W'(Y_MIN);

  // Gravity step with terminal-velocity floor at -VMAX.
  function automatic logic signed [V_W-1:0] fall_vel(input logic signed [V_W-1:0] v);
    logic signed [V_W:0] d;
    d = (V_W+1)'(v) - GRAV_S;
    if (d < VMIN_S) d = VMIN_S;
    return d[V_W-1:0];
  endfunction

  // Unsigned y plus sign-extended velocity.
  function automatic logic signed [YS_W-1:0] add_y(input logic [Y_W-1:0] y,
                                                   input logic signed [V_W-1:0] v);
    return $signed({2'b00, y}) + YS_W'(v);
  endfunction

  // Score increment saturating at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] max_score(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                   state;
  logic                     flap_prev;
  logic                     flap_pending;
  logic                     score_pending;
  logic                     flap_req;
  logic                     score_req;
  logic                     cd_idle;
  logic                     flap_acc;
  logic signed [V_W-1:0]    vel_n;
  logic signed [YS_W-1:0]   y_sum;
  logic [SCORE_W-1:0]       score_n;

  assign game_state = state;
  assign bird_x     = X_W'(START_X);

  // Requests seen this clock count together with anything latched since the last tick.
  assign flap_req  = flap_pending | (flap & ~flap_prev);
  assign score_req = score_pending | pipe_passed;
  assign flap_acc  = flap_req & cd_idle;

  // Candidate FLY update for the current tick.
  always_comb begin
    vel_n   = flap_acc ? FLAP_S : fall_vel(velocity);
    y_sum   = add_y(bird_y, vel_n);
    score_n = score_req ? sat_inc(current_score) : current_score;
  end

`ifdef FLAP_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN + 1);
  logic [CD_W-1:0] cooldown;

  assign cd_idle = (cooldown == '0);

  // Cooldown counts FLY ticks after an accepted flap; frozen in PAUSE, cleared elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cooldown <= '0;
    end else if (tick) begin
      if (state == FLY && !pause) begin
        if (collide)          cooldown <= '0;
        else if (!cd_idle)    cooldown <= cooldown - 1'b1;
        else if (flap_req)    cooldown <= CD_W'(COOLDOWN);
      end else if (state == IDLE || state == DEAD) begin
        cooldown <= '0;
      end
    end
  end
`else
  assign cd_idle = 1'b1;
`endif

  // Request latching, game FSM, physics and scoring.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flap_prev     <= 1'b0;
      flap_pending  <= 1'b0;
      score_pending <= 1'b0;
      bird_y        <= Y_W'(START_Y);
      velocity      <= '0;
      current_score <= '0;
      highest_score <= '0;
    end else begin
      flap_prev <= flap;
      if (!tick) begin
        if (flap & ~flap_prev) flap_pending  <= 1'b1;
        if (pipe_passed)       score_pending <= 1'b1;
      end else begin
        flap_pending  <= 1'b0;
        score_pending <= 1'b0;
        case (state)
          IDLE: begin
            if (flap_req && !pause) begin
              state         <= FLY;
              current_score <= '0;
              velocity      <= FLAP_S;
              bird_y        <= Y_W'(START_Y + FLAP_VEL);
            end
          end
          FLY: begin
            if (pause) begin
              state <= PAUSE;
            end else if (collide) begin
              state         <= DEAD;
              velocity      <= '0;
              highest_score <= max_score(highest_score, current_score);
            end else begin
              current_score <= score_n;
              if (y_sum >= YMAX_S) begin
                bird_y   <= Y_W'(Y_MAX);
                velocity <= '0;
              end else if (y_sum <= YMIN_S) begin
                bird_y        <= Y_W'(Y_MIN);
                velocity      <= '0;
                state         <= DEAD;
                highest_score <= max_score(highest_score, score_n);
              end else begin
                bird_y   <= y_sum[Y_W-1:0];
                velocity <= vel_n;
              end
            end
          end
          PAUSE: begin
            if (!pause) state <= FLY;
          end
          DEAD: begin
            if (restart) begin
              state    <= IDLE;
              bird_y   <= Y_W'(START_Y);
              velocity <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
